// File: rtl/game_pkg.sv
// Shared types and constants for the two-row tile game controller.
package game_pkg;

   localparam int ROW_W   = 10;
   localparam int COL_W   = 4;
   localparam int SCORE_W = 8;
   localparam int TILE_W  = 4;

   localparam logic [TILE_W-1:0] TILE_I = 4'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_REQ,
      ST_PLACE,
      ST_CLEAR,
      ST_OVER
   } state_t;

   // Occupancy mask of a tile whose leftmost column is col; column 0 is the MSB.
   function automatic logic [ROW_W-1:0] span_mask(input logic is_i, input logic [COL_W-1:0] col);
      logic [ROW_W-1:0] base;
      base = is_i ? {4'hF, {(ROW_W-4){1'b0}}} : {2'b11, {(ROW_W-2){1'b0}}};
      return base >> col;
   endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Tile fetch, client placement handshake and game status bundle.
interface game_ctrl_if;
   import game_pkg::*;

   logic                 start;
   logic                 tile_valid;
   logic [TILE_W-1:0]    tile_in;
   logic                 tile_ready;
   logic                 req_to_client;
   logic [TILE_W-1:0]    cur_block;
   logic [ROW_W-1:0]     row1_info;
   logic [ROW_W-1:0]     row2_info;
   logic                 resp_from_client;
   logic [COL_W-1:0]     opt_col;
   logic [1:0]           opt_rotation;
   logic [SCORE_W-1:0]   score;
   logic                 game_over;
   logic                 timeout;

   modport slave (
      input  start, tile_valid, tile_in, resp_from_client, opt_col, opt_rotation,
      output tile_ready, req_to_client, cur_block, row1_info, row2_info, score, game_over, timeout
   );

   modport master (
      output start, tile_valid, tile_in, resp_from_client, opt_col, opt_rotation,
      input  tile_ready, req_to_client, cur_block, row1_info, row2_info, score, game_over, timeout
   );

endinterface

// File: rtl/game_ctrl_line_clear.sv
// Combinational row compaction: removes full rows and reports how many were cleared.
module line_clear
   import game_pkg::*;
(
   input  logic [ROW_W-1:0] row1,
   input  logic [ROW_W-1:0] row2,
   output logic [ROW_W-1:0] new_row1,
   output logic [ROW_W-1:0] new_row2,
   output logic [1:0]       cleared
);

   logic full1;
   logic full2;

   assign full1 = &row1;
   assign full2 = &row2;

   // NOTE: every output gets a default first so no path leaves a latch behind.
   always_comb begin
      new_row1 = row1;
      new_row2 = row2;
      cleared  = 2'd0;
      if (full1 && full2) begin
         new_row1 = '0;
         new_row2 = '0;
         cleared  = 2'd2;
      end else if (full1) begin
         new_row1 = row2;
         new_row2 = '0;
         cleared  = 2'd1;
      end else if (full2) begin
         new_row2 = '0;
         cleared  = 2'd1;
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// Two-row tile game controller: fetch tile, ask client for placement, place, clear lines.
// Optional request timeout enabled by defining GAME_CTRL_TIMEOUT_EN.
module game_ctrl
   import game_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   game_ctrl_if.slave bus
);

   localparam logic [7:0]       REQ_LAST  = 8'(TIMEOUT - 1);
   localparam logic [COL_W-1:0] I_MAX_COL = COL_W'(ROW_W - 4);
   localparam logic [COL_W-1:0] O_MAX_COL = COL_W'(ROW_W - 2);

   state_t               state, state_nxt;
   logic [TILE_W-1:0]    cur_block;
   logic [ROW_W-1:0]     row1, row2;
   logic [ROW_W-1:0]     put_row1, put_row2;
   logic [ROW_W-1:0]     clr_row1, clr_row2;
   logic [1:0]           clr_cnt;
   logic [SCORE_W-1:0]   score;
   logic [SCORE_W:0]     score_sum;
   logic [COL_W-1:0]     col_q;
   logic [1:0]           rot_q;
   logic [7:0]           req_cnt;
   logic                 resp_take;
   logic                 req_done;
   logic                 is_i;
   logic                 place_ok;
   logic [ROW_W-1:0]     mask;
   logic                 free1, free2;

   // The first REQ cycle has req_cnt == 0, so a response there is never taken.
   assign resp_take = (state == ST_REQ) && (req_cnt != 8'd0) && bus.resp_from_client;

`ifdef GAME_CTRL_TIMEOUT_EN
   logic tmo_hit;
   logic timeout_q;

   assign tmo_hit  = (state == ST_REQ) && !resp_take && (req_cnt == REQ_LAST);
   assign req_done = resp_take || tmo_hit;

   always_ff @(posedge clk) begin
      if (rst)          timeout_q <= 1'b0;
      else if (tmo_hit) timeout_q <= 1'b1;
   end

   assign bus.timeout = timeout_q;
`else
   assign req_done    = resp_take;
   assign bus.timeout = 1'b0;
`endif

   line_clear u_clear (
      .row1     (row1),
      .row2     (row2),
      .new_row1 (clr_row1),
      .new_row2 (clr_row2),
      .cleared  (clr_cnt)
   );

   assign score_sum = {1'b0, score} + {{(SCORE_W-1){1'b0}}, clr_cnt};

   always_comb begin
      is_i     = (cur_block == TILE_I);
      mask     = span_mask(is_i, col_q);
      free1    = (row1 & mask) == '0;
      free2    = (row2 & mask) == '0;
      place_ok = 1'b0;
      put_row1 = row1;
      put_row2 = row2;
      if (is_i) begin
         if (col_q <= I_MAX_COL && rot_q == 2'd0) begin
            if (free1 && free2) begin
               put_row1 = row1 | mask;
               place_ok = 1'b1;
            end else if (free2) begin
               put_row2 = row2 | mask;
               place_ok = 1'b1;
            end
         end
      end else if (col_q <= O_MAX_COL && free1 && free2) begin
         put_row1 = row1 | mask;
         put_row2 = row2 | mask;
         place_ok = 1'b1;
      end
   end

   always_comb begin
      state_nxt         = state;
      bus.tile_ready    = (state == ST_FETCH);
      bus.req_to_client = (state == ST_REQ);
      bus.game_over     = (state == ST_OVER);
      case (state)
         ST_IDLE:  if (bus.start)      state_nxt = ST_FETCH;
         ST_FETCH: if (bus.tile_valid) state_nxt = ST_REQ;
         ST_REQ:   if (req_done)       state_nxt = ST_PLACE;
         ST_PLACE: state_nxt = place_ok ? ST_CLEAR : ST_OVER;
         ST_CLEAR: state_nxt = ST_FETCH;
         ST_OVER:  if (bus.start)      state_nxt = ST_FETCH;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cur_block <= '0;
         row1      <= '0;
         row2      <= '0;
         score     <= '0;
         col_q     <= '0;
         rot_q     <= '0;
         req_cnt   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_FETCH: if (bus.tile_valid) begin
               cur_block <= bus.tile_in;
               req_cnt   <= '0;
            end
            ST_REQ: begin
               if (resp_take) begin
                  col_q <= bus.opt_col;
                  rot_q <= bus.opt_rotation;
               end else if (req_done) begin
                  col_q <= '0;
                  rot_q <= '0;
               end else if (req_cnt < REQ_LAST) begin
                  req_cnt <= req_cnt + 8'd1;
               end
            end
            ST_PLACE: if (place_ok) begin
               row1 <= put_row1;
               row2 <= put_row2;
            end
            ST_CLEAR: begin
               row1  <= clr_row1;
               row2  <= clr_row2;
               score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            end
            ST_OVER: if (bus.start) begin
               row1 <= '0;
               row2 <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.cur_block = cur_block;
   assign bus.row1_info = row1;
   assign bus.row2_info = row2;
   assign bus.score     = score;

endmodule
